// File: rtl/hdmi_defs_pkg.sv
// Shared encodings for the HDMI RGB-to-YCbCr processing path.
package hdmi_defs;

   // Converter processing modes carried on mode_req / mode.
   typedef enum logic [1:0] {
      MODE_BYPASS = 2'd0,
      MODE_YCBCR  = 2'd1,
      MODE_LUMA   = 2'd2,
      MODE_RSVD   = 2'd3
   } mode_e;

   // Video lock sequencer states.
   typedef enum logic [1:0] {
      ST_UNLOCKED = 2'd0,
      ST_ACQUIRE  = 2'd1,
      ST_LOCKED   = 2'd2
   } state_e;

   // Receiver control signals travelling alongside the pixel pipeline.
   typedef struct packed {
      logic vsync;
      logic hsync;
      logic de;
   } sync_t;

   localparam int unsigned SYNC_W = $bits(sync_t);

   // Width of the consecutive-match counter; LOCK_FRAMES is at most 15.
   localparam int unsigned MCNT_W = 4;

   // Status LED bit positions.
   localparam int unsigned LED_LOCKED  = 7;
   localparam int unsigned LED_PEND    = 6;
   localparam int unsigned LED_MODE_HI = 5;
   localparam int unsigned LED_MODE_LO = 4;
   localparam int unsigned LED_FCNT_HI = 3;
   localparam int unsigned LED_FCNT_LO = 0;

endpackage

// File: rtl/sync_delay.sv
// DEPTH x WIDTH shift register aligning control signals with the pixel pipeline.
module sync_delay #(
   parameter int unsigned DEPTH = 3,
   parameter int unsigned WIDTH = 3
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] dout_o
);

   logic [DEPTH-1:0][WIDTH-1:0] taps_q;
   logic [DEPTH-1:0][WIDTH-1:0] taps_d;

   // Stage 0 takes the input, each further stage takes its predecessor.
   if (DEPTH == 1) begin : g_single
      assign taps_d = din_i;
   end else begin : g_multi
      assign taps_d = {taps_q[DEPTH-2:0], din_i};
   end

   // Tap registers, cleared so the outputs are quiet after reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         taps_q <= '0;
      end else begin
         taps_q <= taps_d;
      end
   end

   assign dout_o = taps_q[DEPTH-1];

endmodule

// File: rtl/ycbcr_proc_ctrl.sv
// Frame-level sequencer: video lock detection, frame-aligned mode changes,
// control-signal delay matching and status LEDs.
module ycbcr_proc_ctrl
   import hdmi_defs::*;
#(
   parameter int unsigned LATENCY     = 3,
   parameter int unsigned LOCK_FRAMES = 4,
   parameter int unsigned LCNT_W      = 12
) (
   input  logic       clk100,
   input  logic       rstbtn_n,
   input  logic       vsync_in,
   input  logic       hsync_in,
   input  logic       de_in,
   input  logic [1:0] mode_req,
   input  logic       mode_req_vld,
   output logic [1:0] mode,
   output logic       vsync_out,
   output logic       hsync_out,
   output logic       de_out,
   output logic       locked,
   output logic [7:0] frame_cnt,
   output logic [7:0] LED
);

   localparam int unsigned WD_W = LCNT_W + 10;

   logic              vsync_q, hsync_q;
   logic [LCNT_W-1:0] lcnt_q, lcnt_d;
   logic [LCNT_W-1:0] ref_q, ref_d;
   logic [MCNT_W-1:0] match_q, match_d, match_inc;
   logic [WD_W-1:0]   wd_q, wd_d;
   logic [7:0]        frame_q, frame_d;
   logic [1:0]        mode_q, mode_d;
   logic [1:0]        req_q, req_d;
   logic              pend_q, pend_d;
   logic              locked_q, locked_d;
   state_e            state_q, state_d;

   logic              fs, line_start, lcnt_sat, lines_match, wd_expire, req_ok;
   logic [7:0]        led_c;
   sync_t             sync_in, sync_dly;

   // Edge detection on the receiver syncs.
   assign fs          = vsync_in & ~vsync_q;
   assign line_start  = hsync_in & ~hsync_q;
   assign lcnt_sat    = &lcnt_q;
   assign lines_match = !lcnt_sat && (lcnt_q == ref_q);
   assign wd_expire   = !fs && (&wd_q);
   assign req_ok      = mode_req_vld && (mode_req != MODE_RSVD);
   assign match_inc   = match_q + MCNT_W'(1);

   // Line counter, frame counter and missing-vsync watchdog.
   always_comb begin
      lcnt_d  = lcnt_q;
      frame_d = frame_q;
      wd_d    = wd_q + WD_W'(1);
      if (fs) begin
         lcnt_d  = line_start ? LCNT_W'(1) : '0;
         frame_d = frame_q + 8'd1;
         wd_d    = '0;
      end else if (line_start && !lcnt_sat) begin
         lcnt_d = lcnt_q + LCNT_W'(1);
      end
   end

   // Lock sequencer: compares each completed frame's line count with the reference.
   always_comb begin
      state_d = state_q;
      match_d = match_q;
      ref_d   = ref_q;
      if (fs) begin
         unique case (state_q)
            ST_UNLOCKED: begin
               state_d = ST_ACQUIRE;
               match_d = '0;
               ref_d   = lcnt_q;
            end
            ST_ACQUIRE: begin
               if (lines_match) begin
                  match_d = match_inc;
                  if (match_inc == MCNT_W'(LOCK_FRAMES - 1)) begin
                     state_d = ST_LOCKED;
                  end
               end else begin
                  match_d = '0;
                  ref_d   = lcnt_q;
               end
            end
            ST_LOCKED: begin
               if (!lines_match) begin
                  state_d = ST_UNLOCKED;
               end
            end
            default: state_d = ST_UNLOCKED;
         endcase
      end
      if (wd_expire) begin
         state_d = ST_UNLOCKED;
      end
      locked_d = (state_d == ST_LOCKED);
   end

   // Mode handshake: requests wait for a frame boundary unless they arrive on one.
   always_comb begin
      mode_d = mode_q;
      req_d  = req_q;
      pend_d = pend_q;
      if (fs) begin
         if (req_ok) begin
            mode_d = mode_req;
         end else if (pend_q) begin
            mode_d = req_q;
         end
         pend_d = 1'b0;
      end else if (req_ok) begin
         req_d  = mode_req;
         pend_d = 1'b1;
      end
   end

   // Sequencer state register.
   always_ff @(posedge clk100 or negedge rstbtn_n) begin
      if (!rstbtn_n) begin
         state_q  <= ST_UNLOCKED;
         match_q  <= '0;
         ref_q    <= '0;
         locked_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         match_q  <= match_d;
         ref_q    <= ref_d;
         locked_q <= locked_d;
      end
   end

   // Datapath registers: sync history, counters and mode handshake.
   always_ff @(posedge clk100 or negedge rstbtn_n) begin
      if (!rstbtn_n) begin
         vsync_q <= 1'b0;
         hsync_q <= 1'b0;
         lcnt_q  <= '0;
         wd_q    <= '0;
         frame_q <= '0;
         mode_q  <= MODE_BYPASS;
         req_q   <= MODE_BYPASS;
         pend_q  <= 1'b0;
      end else begin
         vsync_q <= vsync_in;
         hsync_q <= hsync_in;
         lcnt_q  <= lcnt_d;
         wd_q    <= wd_d;
         frame_q <= frame_d;
         mode_q  <= mode_d;
         req_q   <= req_d;
         pend_q  <= pend_d;
      end
   end

   // Status LED map, assembled purely from registered state.
   always_comb begin
      led_c                            = '0;
      led_c[LED_LOCKED]                = locked_q;
      led_c[LED_PEND]                  = pend_q;
      led_c[LED_MODE_HI:LED_MODE_LO]   = mode_q;
      led_c[LED_FCNT_HI:LED_FCNT_LO]   = frame_q[7:4];
   end

   assign sync_in = {vsync_in, hsync_in, de_in};

   sync_delay #(
      .DEPTH (LATENCY),
      .WIDTH (SYNC_W)
   ) u_sync_delay (
      .clk_i  (clk100),
      .rst_ni (rstbtn_n),
      .din_i  (sync_in),
      .dout_o (sync_dly)
   );

   assign vsync_out = sync_dly.vsync;
   assign hsync_out = sync_dly.hsync;
   assign de_out    = sync_dly.de;
   assign mode      = mode_q;
   assign locked    = locked_q;
   assign frame_cnt = frame_q;
   assign LED       = led_c;

endmodule

// File: tb/tb_ycbcr_proc_ctrl.sv
// Directed testbench for ycbcr_proc_ctrl.
module tb_ycbcr_proc_ctrl;

   localparam int LAT = 3;

   logic       clk100 = 1'b0;
   logic       rstbtn_n;
   logic       vsync_in, hsync_in, de_in;
   logic [1:0] mode_req;
   logic       mode_req_vld;
   logic [1:0] mode;
   logic       vsync_out, hsync_out, de_out;
   logic       locked;
   logic [7:0] frame_cnt;
   logic [7:0] LED;

   int n_cmp = 0;
   int n_bad = 0;

   logic       nxt_vld;
   logic [1:0] nxt_m;
   logic [2:0] hist[$];
   bit         prev_rst;

   ycbcr_proc_ctrl #(
      .LATENCY     (LAT),
      .LOCK_FRAMES (4),
      .LCNT_W      (12)
   ) dut (
      .clk100       (clk100),
      .rstbtn_n     (rstbtn_n),
      .vsync_in     (vsync_in),
      .hsync_in     (hsync_in),
      .de_in        (de_in),
      .mode_req     (mode_req),
      .mode_req_vld (mode_req_vld),
      .mode         (mode),
      .vsync_out    (vsync_out),
      .hsync_out    (hsync_out),
      .de_out       (de_out),
      .locked       (locked),
      .frame_cnt    (frame_cnt),
      .LED          (LED)
   );

   always #5 clk100 = ~clk100;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock: drive just after posedge, return at the following negedge.
   task automatic step(input logic v, input logic h, input logic d);
      @(posedge clk100);
      #1;
      vsync_in     = v;
      hsync_in     = h;
      de_in        = d;
      mode_req_vld = nxt_vld;
      mode_req     = nxt_m;
      nxt_vld      = 1'b0;
      @(negedge clk100);
   endtask

   // vsync rising edge; on return the fs results are visible.
   task automatic fs_edge();
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
   endtask

   task automatic lines(input int n);
      repeat (n) begin
         step(1'b0, 1'b1, 1'b0);
         step(1'b0, 1'b0, 1'b1);
         step(1'b0, 1'b0, 1'b1);
         step(1'b0, 1'b0, 1'b0);
      end
   endtask

   task automatic req(input logic [1:0] m);
      nxt_vld = 1'b1;
      nxt_m   = m;
      step(1'b0, 1'b0, 1'b0);
   endtask

   // Delay-line step: record what the taps should hold and compare the output
   // with the input applied LAT cycles earlier (zero where reset intervened).
   task automatic dstep(input logic [2:0] val, input bit rst);
      @(posedge clk100);
      #1;
      {vsync_in, hsync_in, de_in} = val;
      mode_req_vld = 1'b0;
      rstbtn_n     = !rst;
      if (rst && !prev_rst) begin
         for (int j = 1; j <= LAT; j++) begin
            if (hist.size() >= j) hist[hist.size() - j] = 3'b000;
         end
      end
      prev_rst = rst;
      hist.push_back(rst ? 3'b000 : val);
      @(negedge clk100);
      if (hist.size() > LAT) begin
         chk("sync_dly", 32'({vsync_out, hsync_out, de_out}), 32'(hist[hist.size() - 1 - LAT]));
      end
   endtask

   initial begin
      rstbtn_n     = 1'b0;
      vsync_in     = 1'b0;
      hsync_in     = 1'b0;
      de_in        = 1'b0;
      mode_req     = 2'd0;
      mode_req_vld = 1'b0;
      nxt_vld      = 1'b0;
      nxt_m        = 2'd0;
      prev_rst     = 1'b0;

      // Reset values.
      repeat (3) @(negedge clk100);
      chk("rst_locked", 32'(locked), 32'd0);
      chk("rst_mode", 32'(mode), 32'd0);
      chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
      chk("rst_led", 32'(LED), 32'h00);
      chk("rst_sync_out", 32'({vsync_out, hsync_out, de_out}), 32'd0);
      rstbtn_n = 1'b1;
      repeat (3) step(1'b0, 1'b0, 1'b0);

      // Acquisition: fs1 enters ACQUIRE (ref 0), fs2 sets ref 525, fs3..fs5 match.
      for (int k = 1; k <= 6; k++) begin
         fs_edge();
         chk("acq_frame_cnt", 32'(frame_cnt), 32'(k));
         chk("acq_locked", 32'(locked), 32'(k >= 5));
         lines(525);
      end
      chk("locked_led", 32'(LED), 32'h80);

      // Single request applied at the next frame boundary.
      fs_edge();
      chk("f7_locked", 32'(locked), 32'd1);
      lines(200);
      req(2'd1);
      step(1'b0, 1'b0, 1'b0);
      chk("pend_set_led", 32'(LED), 32'hC0);
      lines(325);
      chk("pend_hold_mode", 32'(mode), 32'd0);
      fs_edge();
      chk("apply_mode1", 32'(mode), 32'd1);
      chk("apply_led", 32'(LED), 32'h90);

      // Later request overwrites earlier one; reserved code is ignored.
      lines(100);
      req(2'd2);
      lines(10);
      req(2'd1);
      step(1'b0, 1'b0, 1'b0);
      chk("overwrite_led", 32'(LED), 32'hD0);
      req(2'd3);
      step(1'b0, 1'b0, 1'b0);
      chk("rsvd_pend_led", 32'(LED), 32'hD0);
      lines(415);
      fs_edge();
      chk("overwrite_mode", 32'(mode), 32'd1);
      chk("overwrite_clr", 32'(LED), 32'h90);

      // Reserved with nothing pending; then a request on the fs clock itself.
      lines(100);
      req(2'd3);
      step(1'b0, 1'b0, 1'b0);
      chk("rsvd_idle_led", 32'(LED), 32'h90);
      lines(425);
      nxt_vld = 1'b1;
      nxt_m   = 2'd2;
      fs_edge();
      chk("same_cyc_mode", 32'(mode), 32'd2);
      chk("same_cyc_led", 32'(LED), 32'hA0);

      // Short frame drops lock, then four more frames re-lock.
      lines(520);
      fs_edge();
      chk("short_unlock", 32'(locked), 32'd0);
      chk("short_led", 32'(LED), 32'h20);
      for (int j = 1; j <= 4; j++) begin
         lines(525);
         fs_edge();
         chk("relock", 32'(locked), 32'(j == 4));
      end
      chk("relock_frame_cnt", 32'(frame_cnt), 32'd15);

      // frame_cnt wrap; empty frames re-lock on a zero line count.
      repeat (240) begin
         step(1'b0, 1'b0, 1'b0);
         fs_edge();
      end
      chk("fcnt_255", 32'(frame_cnt), 32'd255);
      chk("fcnt_255_led", 32'(LED), 32'hAF);
      step(1'b0, 1'b0, 1'b0);
      fs_edge();
      chk("fcnt_wrap", 32'(frame_cnt), 32'd0);
      chk("fcnt_wrap_led", 32'(LED), 32'hA0);

      // Drive into ACQUIRE with a pending request, then reset asynchronously.
      lines(3);
      fs_edge();
      chk("pre_rst_unlock", 32'(locked), 32'd0);
      step(1'b0, 1'b0, 1'b0);
      fs_edge();
      req(2'd1);
      step(1'b0, 1'b0, 1'b0);
      chk("acq_pend_led", 32'(LED), 32'h60);
      #2;
      rstbtn_n = 1'b0;
      #1;
      chk("async_locked", 32'(locked), 32'd0);
      chk("async_mode", 32'(mode), 32'd0);
      chk("async_led", 32'(LED), 32'h00);
      chk("async_fcnt", 32'(frame_cnt), 32'd0);
      @(negedge clk100);
      rstbtn_n = 1'b1;

      // First fs after release starts acquisition; pending request was discarded.
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      fs_edge();
      chk("post_rst_fcnt", 32'(frame_cnt), 32'd1);
      chk("post_rst_mode", 32'(mode), 32'd0);
      chk("post_rst_locked", 32'(locked), 32'd0);
      for (int j = 1; j <= 4; j++) begin
         lines(7);
         fs_edge();
         chk("post_rst_lock", 32'(locked), 32'(j == 4));
      end

      // Delay line under random stimulus with a reset pulse in the middle.
      hist.delete();
      for (int i = 0; i < 64; i++) begin
         logic [2:0] v;
         v = (i >= 26 && i < 30) ? 3'b111 : 3'($urandom_range(7));
         dstep(v, (i >= 30 && i < 33));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ycbcr_proc_ctrl.md
Name: ycbcr_proc_ctrl

Overview:
- Frame-level sequencer for the RGB-to-YCbCr processing path between the HDMI receiver and transmitter in hdmi_main.
- Monitors receiver sync to detect a stable video lock.
- Commits processing-mode changes only at frame boundaries.
- Delays hsync/vsync/de by the conversion pipeline latency so the transmitter sees aligned control signals.
- Drives the status LEDs.

Parameters:
- LATENCY, 3, pixel-pipeline depth of the colour converter in clocks; 1..15.
- LOCK_FRAMES, 4, consecutive frames with equal line count needed to declare lock; 2..15.
- LCNT_W, 12, width of the per-frame line counter.

Ports:
- clk100  in  1  block clock; all sync inputs are already synchronous to it.
- rstbtn_n  in  1  asynchronous active-low reset.
- vsync_in  in  1  receiver vsync, active high.
- hsync_in  in  1  receiver hsync, active high.
- de_in  in  1  receiver data enable.
- mode_req  in  2  requested mode: 0 bypass, 1 YCbCr444, 2 luma-only, 3 reserved.
- mode_req_vld  in  1  one-cycle strobe qualifying mode_req.
- mode  out  2  mode currently applied to the converter.
- vsync_out  out  1  vsync_in delayed LATENCY clocks.
- hsync_out  out  1  hsync_in delayed LATENCY clocks.
- de_out  out  1  de_in delayed LATENCY clocks.
- locked  out  1  high in LOCKED state.
- frame_cnt  out  8  free-running frame counter, wraps 255->0.
- LED  out  8  {locked, pend, mode[1:0], frame_cnt[7:4]}.

Behaviour:
- Reset values (async assert, release synchronous to clk100):
  - mode=0, all delay-line taps=0, locked=0, frame_cnt=0, line counter=0, pend=0, state=UNLOCKED.
  - LED therefore resets to 0x00.
- Frame start (fs): rising edge of vsync_in, i.e. vsync_in=1 with registered previous value 0.
- Line start: rising edge of hsync_in.
- Line counter:
  - Increments on each line start.
  - On fs, the count is captured as last_lines and the counter clears to 0. If a line start coincides with fs, the counter loads 1.
  - Saturates at all-ones and does not wrap. A saturated count never matches.
- frame_cnt increments by 1 on every fs, regardless of state.
- State machine, with transitions evaluated on fs:
  - UNLOCKED: on fs, go to ACQUIRE with match_cnt=0 and ref_lines=captured count.
  - ACQUIRE, count == ref_lines: match_cnt+1. When match_cnt reaches LOCK_FRAMES-1, go to LOCKED.
  - ACQUIRE, count differs: match_cnt=0 and ref_lines=new count; stay in ACQUIRE.
  - LOCKED: a count different from ref_lines goes to UNLOCKED.
  - Watchdog (all states): no fs for 2^(LCNT_W+10) clocks forces UNLOCKED.
- Mode handshake:
  - mode_req_vld with mode_req != 3 latches the request and sets pend=1. A later request overwrites an earlier pending one.
  - mode_req=3 is ignored.
  - While pend=1, mode updates on the clock where fs is detected, and pend clears on that same clock.
  - Same-cycle mode_req_vld and fs: the new request is applied immediately and pend stays 0.
  - While UNLOCKED, the pending request is still applied on fs. If no fs ever arrives, the request stays pending.
- Delay line:
  - Shift register of depth LATENCY per signal; vsync_out equals vsync_in from exactly LATENCY cycles earlier.
  - It does not depend on state or mode.
- Reset mid-frame: all state clears immediately; the first fs after release starts acquisition.

Decomposition:
- Shared package (include file) hdmi_defs:
  - Mode encodings MODE_BYPASS=0, MODE_YCBCR=1, MODE_LUMA=2.
  - State encodings ST_UNLOCKED, ST_ACQUIRE, ST_LOCKED.
  - LED bit positions.
- One sub-module: sync_delay, a parameterised DEPTH x WIDTH shift register instantiated once with WIDTH=3.

Test Plan:
- Reset, then 6 frames of 525 lines with LOCK_FRAMES=4:
  - locked rises on the fs ending frame 5 (1 fs to ACQUIRE, then 3 matches).
  - frame_cnt=6; LED[7]=1.
- Locked stream, then one frame of 520 lines: locked drops at that frame's closing fs, then re-locks 4 frames later.
- mode_req=1 strobe mid-frame:
  - pend=1 and LED[6]=1 until next fs.
  - On the fs clock, mode=1 and pend=0.
- mode_req=2 then mode_req=1 in the same frame: only mode=1 is applied at fs. mode_req=3 strobe leaves mode and pend unchanged.
- Random vsync/hsync/de pattern with LATENCY=3: outputs equal inputs shifted exactly 3 cycles, including around a reset pulse, after which the outputs are 0 for 3 cycles.
- frame_cnt at 255 plus fs: wraps to 0.
- rstbtn_n asserted mid-acquire: locked=0, mode=0, LED=0x00 immediately without a clock edge.
